// File: rtl/alu_regbank_pkg.sv
// alu_regbank_pkg: shared widths, ALU opcodes and flag bundle for the ALU operand/result stage
package alu_regbank_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int AW_DEF = 4;
  localparam int NREG_DEF = 16;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_NEGA = 3'b010,
    OP_NEGB = 3'b011,
    OP_AND  = 3'b100,
    OP_OR   = 3'b101,
    OP_XOR  = 3'b110,
    OP_NOTA = 3'b111
  } alu_op_e;
  typedef struct packed {
    logic z;
    logic c;
    logic s;
  } flags_t;
  function automatic logic op_is_logic(input alu_op_e op);
    return op[2];
  endfunction
endpackage

// File: rtl/alu_regbank_flag_reg.sv
// alu_regbank_flag_reg: z/c/s flag register; logical ops leave c/s untouched since the ALU drives them to x
module alu_regbank_flag_reg
  import alu_regbank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fe,
  input  logic l_in,
  input  logic z_in,
  input  logic c_in,
  input  logic s_in,
  output logic zf,
  output logic cf,
  output logic sf
);
  flags_t flags_q, flags_d;
  always_comb begin
    flags_d = flags_q;
    flags_d.z = fe ? z_in : flags_q.z;
    flags_d.c = (fe && !l_in) ? c_in : flags_q.c;
    flags_d.s = (fe && !l_in) ? s_in : flags_q.s;
  end
  always_ff @(posedge clk) begin
    if (reset) flags_q <= '0;
    else flags_q <= flags_d;
  end
  assign zf = flags_q.z;
  assign cf = flags_q.c;
  assign sf = flags_q.s;
endmodule

// File: rtl/alu_regbank.sv
// alu_regbank: register bank with two combinational read ports and one write port, plus ALU flag register
module alu_regbank
  import alu_regbank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW = AW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             fe,
  input  logic             l_in,
  input  logic             z_in,
  input  logic             c_in,
  input  logic             s_in,
  output logic             zf,
  output logic             cf,
  output logic             sf
);
  // register 0 is a constant zero, so only 1..NREG-1 have storage
  logic [WIDTH-1:0] bank_q [1:NREG-1];
  logic [WIDTH-1:0] bank_d [1:NREG-1];
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 1; i < NREG; i++) begin
      rd1 = (ra1 == AW'(i)) ? bank_q[i] : rd1;
      rd2 = (ra2 == AW'(i)) ? bank_q[i] : rd2;
      bank_d[i] = (we && wa == AW'(i)) ? wd : bank_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) for (int i = 1; i < NREG; i++) bank_q[i] <= '0;
    else bank_q <= bank_d;
  end
  alu_regbank_flag_reg u_flag_reg (
    .clk  (clk),
    .reset(reset),
    .fe   (fe),
    .l_in (l_in),
    .z_in (z_in),
    .c_in (c_in),
    .s_in (s_in),
    .zf   (zf),
    .cf   (cf),
    .sf   (sf)
  );
endmodule

// File: tb/tb_alu_regbank.sv
// tb_alu_regbank: directed and randomized checks of alu_regbank against an array/arithmetic reference model
module tb_alu_regbank;
  import alu_regbank_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] ra1 = '0, ra2 = '0, wa = '0, wd = '0;
  logic [3:0] rd1, rd2;
  logic we = 1'b0, fe = 1'b0, l_in = 1'b0, z_in = 1'b0, c_in = 1'b0, s_in = 1'b0;
  logic zf, cf, sf;
  logic [3:0] m_bank [16];
  logic m_z, m_c, m_s;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  alu_regbank dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .fe(fe), .l_in(l_in), .z_in(z_in), .c_in(c_in),
    .s_in(s_in), .zf(zf), .cf(cf), .sf(sf)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, ".rd1"}, 8'(rd1), 8'(m_bank[ra1]));
    check({tag, ".rd2"}, 8'(rd2), 8'(m_bank[ra2]));
    check({tag, ".flags"}, {5'b0, zf, cf, sf}, {5'b0, m_z, m_c, m_s});
  endtask
  // advance one edge, updating the model from the inputs held across it
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      foreach (m_bank[i]) m_bank[i] = '0;
      {m_z, m_c, m_s} = '0;
    end else begin
      if (we && wa != 0) m_bank[wa] = wd;
      if (fe) begin
        m_z = z_in;
        if (!l_in) {m_c, m_s} = {c_in, s_in};
      end
    end
    #1;
  endtask
  task automatic idle();
    we = 0;
    fe = 0;
  endtask
  task automatic write(input logic [3:0] a, input logic [3:0] d);
    we = 1; wa = a; wd = d; fe = 0;
    tick();
    idle();
  endtask
  function automatic logic [7:0] alu(input alu_op_e op, input logic [3:0] a, input logic [3:0] b);
    int r;
    logic [3:0] res;
    logic c;
    case (op)
      OP_ADD:  r = int'(a) + int'(b);
      OP_SUB:  r = int'(a) + int'(~b) + 1;
      OP_NEGA: r = int'(~a) + 1;
      OP_NEGB: r = int'(~b) + 1;
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_XOR:  r = int'(a ^ b);
      default: r = int'(~a);
    endcase
    res = 4'(r);
    c = (r > 15);
    return {res, op[2], res == 0, c, res[3]};
  endfunction
  task automatic alu_op(input alu_op_e op, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    logic [7:0] o;
    ra1 = a;
    ra2 = b;
    o = alu(op, m_bank[a], m_bank[b]);
    we = 1; wa = d; wd = o[7:4]; fe = 1; l_in = o[3]; z_in = o[2]; c_in = o[1]; s_in = o[0];
    tick();
    idle();
    ra1 = d;
    #1;
    check_state("alu_op");
  endtask
  initial begin
    foreach (m_bank[i]) m_bank[i] = '0;
    {m_z, m_c, m_s} = '0;
    @(negedge clk);
    reset = 1; we = 1; wa = 3; wd = 4'hF; fe = 1; z_in = 1; c_in = 1; s_in = 1;
    tick();
    reset = 0;
    idle();
    ra1 = 3;
    #1;
    check("reset.bank3", 8'(rd1), 8'h0);
    check("reset.flags", {5'b0, zf, cf, sf}, 8'h0);
    we = 1; wa = 5; wd = 4'hA; ra1 = 5; ra2 = 0;
    #1;
    check("wr5.before", 8'(rd1), 8'h0);
    tick();
    idle();
    check("wr5.after", 8'(rd1), 8'hA);
    check("wr5.rd2zero", 8'(rd2), 8'h0);
    write(0, 4'h7);
    ra1 = 0;
    #1;
    check("wr0.ignored", 8'(rd1), 8'h0);
    write(2, 4'h1);
    we = 1; wa = 2; wd = 4'h6; ra1 = 2; ra2 = 2;
    #1;
    check("rdw.old", 8'(rd1), 8'h1);
    check("rdw.old2", 8'(rd2), 8'h1);
    tick();
    idle();
    check("rdw.new", 8'(rd1), 8'h6);
    check("rdw.new2", 8'(rd2), 8'h6);
    fe = 1; l_in = 0; z_in = 0; c_in = 1; s_in = 1;
    tick();
    idle();
    check("flag.arith", {5'b0, zf, cf, sf}, 8'h3);
    fe = 1; l_in = 1; z_in = 1; c_in = 0; s_in = 0;
    tick();
    idle();
    check("flag.logic", {5'b0, zf, cf, sf}, 8'h7);
    fe = 0; l_in = 0; z_in = 0;
    tick();
    check("flag.hold", {5'b0, zf, cf, sf}, 8'h7);
    write(2, 4'h3);
    write(3, 4'h5);
    alu_op(OP_SUB, 2, 3, 4);
    check("sub.r4", 8'(rd1), 8'hE);
    check("sub.flags", {5'b0, zf, cf, sf}, 8'h1);
    alu_op(OP_ADD, 3, 4, 5);
    check("add.r5", 8'(rd1), 8'h3);
    check("add.flags", {5'b0, zf, cf, sf}, 8'h2);
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      we = 1'($urandom); wa = 4'($urandom); wd = 4'($urandom);
      fe = 1'($urandom); l_in = 1'($urandom); z_in = 1'($urandom);
      c_in = 1'($urandom); s_in = 1'($urandom);
      ra1 = 4'($urandom); ra2 = 4'($urandom);
      #1;
      check_state("rand.pre");
      tick();
      check_state("rand.post");
    end
    reset = 0;
    for (int n = 0; n < 60; n++) alu_op(alu_op_e'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 4'($urandom));
    for (int r = 1; r < 16; r++) write(4'(r), 4'($urandom));
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ra1 = 4'(a);
        ra2 = 4'(b);
        #1;
        check("sweep.rd1", 8'(rd1), 8'(m_bank[a]));
        check("sweep.rd2", 8'(rd2), 8'(m_bank[b]));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
